// File: rtl/jkff_pkg.sv
// Shared JK command encoding and next-state rule used by every JK bit.
package jkff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(jk_cmd_t cmd, logic q);
    case (cmd)
      JK_HOLD: return q;
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jkff_if.sv
// Bundle of the JK bank data signals; the driver of J/K uses master, the flop bank side uses slave.
interface jkff_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;

  modport master (output j, output k, input q, input qn);
  modport slave  (input j, input k, output q, output qn);

endinterface

// File: rtl/jkff_cell.sv
// Single JK flop bit with asynchronous active-low reset to RESET_BIT.
module jkff_cell
  import jkff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic CLK,
  input  logic N_RESET,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_cmd_t cmd;

  assign cmd = jk_cmd_t'({j, k});

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      q <= RESET_BIT;
    end else begin
      q <= jk_next(cmd, q);
    end
  end

endmodule

// File: rtl/jkff.sv
// WIDTH-bit bank of independent positive-edge JK flops with async active-low reset.
module jkff
  import jkff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             CLK,
  input  logic             N_RESET = 1'b1,
  output logic [WIDTH-1:0] QN
);

  // Positional order above is fixed so legacy benches can wire only Q, J, K, CLK.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .j       (J[i]),
      .k       (K[i]),
      .q       (Q[i])
    );
  end

  assign QN = ~Q;

endmodule

// File: tb/tb_jkff.sv
// Self-checking bench for jkff: directed scenarios, then randomized J/K and reset pulses vs. a reference model.
module tb_jkff;

  localparam logic [3:0] R4 = 4'b0101;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic       m1;
  logic [3:0] m4;

  jkff_if #(.WIDTH(1)) bus1 ();
  jkff_if #(.WIDTH(4)) bus4 ();

  always #5 clk = ~clk;

  jkff u_dut1 (
    .Q       (bus1.q),
    .J       (bus1.j),
    .K       (bus1.k),
    .CLK     (clk),
    .N_RESET (rst_n),
    .QN      (bus1.qn)
  );

  jkff #(.WIDTH(4), .RESET_VAL(R4)) u_dut4 (
    .Q       (bus4.q),
    .J       (bus4.j),
    .K       (bus4.k),
    .CLK     (clk),
    .N_RESET (rst_n),
    .QN      (bus4.qn)
  );

  // Characteristic equation of a JK flop: Q+ = J&~Q | ~K&Q.
  function automatic logic [3:0] jk_ref(logic [3:0] j, logic [3:0] k, logic [3:0] q);
    return (j & ~q) | (~k & q);
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q1"},  {3'b000, bus1.q},  {3'b000, m1});
    check({tag, ".qn1"}, {3'b000, bus1.qn}, {3'b000, ~m1});
    check({tag, ".q4"},  bus4.q,  m4);
    check({tag, ".qn4"}, bus4.qn, ~m4);
  endtask

  task automatic step(input string tag, input logic j1, input logic k1,
                      input logic [3:0] j4, input logic [3:0] k4);
    bus1.j = j1; bus1.k = k1;
    bus4.j = j4; bus4.k = k4;
    @(posedge clk);
    m1 = jk_ref({3'b000, j1}, {3'b000, k1}, {3'b000, m1}) & 4'b0001 ? 1'b1 : 1'b0;
    m4 = jk_ref(j4, k4, m4);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic step1(input string tag, input logic j, input logic k);
    step(tag, j, k, {4{j}}, {4{k}});
  endtask

  // Pulse reset between edges and confirm Q reacts before the next rising edge.
  task automatic mid_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    m1 = 1'b0;
    m4 = R4;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    bus1.j = 1'b1; bus1.k = 1'b1;
    bus4.j = 4'hF; bus4.k = 4'hF;
    m1 = 1'b0;
    m4 = R4;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("reset_hold");
    end

    bus1.j = 1'b0; bus1.k = 1'b0;
    bus4.j = 4'h0; bus4.k = 4'h0;
    rst_n  = 1'b1;
    step1("release", 1'b0, 1'b0);

    step1("set",   1'b1, 1'b0);
    step1("hold1", 1'b0, 1'b0);
    step1("hold2", 1'b0, 1'b0);
    step1("clr",   1'b0, 1'b1);
    step1("hold3", 1'b0, 1'b0);
    step1("tog1",  1'b1, 1'b1);
    step1("tog2",  1'b1, 1'b1);
    step1("hold4", 1'b0, 1'b0);

    step1("pre_rst", 1'b1, 1'b0);
    mid_reset("mid_rst");
    step1("post_rst", 1'b1, 1'b0);

    step("w4_load", 1'b0, 1'b0, 4'b0011, 4'b1100);
    step("w4_mix",  1'b0, 1'b0, 4'b1010, 4'b0110);
    check("w4_mix_abs", bus4.q, 4'b1001);

    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 24) == 0) mid_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
